sd_access_sched: RTL and testbench
==================================

// Module: sd_access_sched
// PURPOSE
//  Sequences the SD SPI engine (init + single-block read) and shares it between two requesters:
//  port 0 = UART command path (fifo_control), port 1 = front-end logic. Ensures the card is
//  initialised once before any read, round-robin arbitrates reads, reports per-port done/err.
// PARAMETERS
//  ADDR_W      32     block address width
//  TIMEOUT_CYC 65535  max clk cycles waiting on init_ok / sd_read_ok (with SD_TIMEOUT_EN)
//  MAX_RETRY   3      init attempts before sticky init failure (1..15)
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  req0/req1   in   1       read request level; held until matching done/err pulse
//  addr0/addr1 in   ADDR_W  block address, sampled in the grant cycle
//  gnt0/gnt1   out  1       one-cycle pulse: request accepted, address latched
//  done0/done1 out  1       one-cycle pulse: block read completed
//  err0/err1   out  1       one-cycle pulse: request aborted (init failure or timeout)
//  sd_init     out  1       to SD engine: start init; held high until init_ok or timeout
//  init_ok     in   1       from SD engine: init finished (level, held while card is ready)
//  sd_ren      out  1       to SD engine: one-cycle read strobe, only while sd_busy=0
//  sd_addr     out  ADDR_W  block address, stable from sd_ren until read completes
//  sd_read_ok  in   1       from SD engine: one-cycle pulse, block delivered
//  sd_busy     in   1       from SD engine: engine busy, no new strobe allowed
//  card_rdy    out  1       card initialised and usable
//  init_fail   out  1       sticky: MAX_RETRY init attempts failed; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0, sd_addr=0, state=IDLE, retry_cnt=0, last_gnt=1 (so port 0 wins first).
//  States: IDLE -> INIT -> ARB -> RD_ISSUE -> RD_WAIT -> ARB; INIT fail path -> FAIL.
//  IDLE: on any req with card_rdy=0 and init_fail=0 -> INIT (sd_init=1 next cycle).
//   card_rdy=1 -> ARB. init_fail=1: any req gets err pulse 1 cycle after req seen, no gnt.
//  INIT: sd_init=1. init_ok=1 -> sd_init=0, card_rdy=1, retry_cnt=0, -> ARB.
//   Timeout -> sd_init=0 for 1 cycle (re-arm), retry_cnt+1; retry_cnt==MAX_RETRY -> FAIL.
//  FAIL: init_fail=1; err pulses to every pending req (both in same cycle if both pending) -> IDLE.
//  ARB: if init_ok drops -> card_rdy=0, -> INIT. Else both req: grant port != last_gnt;
//   single req: grant it. gnt pulse + sd_addr<=addrN same cycle, last_gnt<=N, -> RD_ISSUE.
//  RD_ISSUE: wait sd_busy=0, then sd_ren=1 exactly one cycle, -> RD_WAIT.
//  RD_WAIT: sd_read_ok -> doneN pulse next cycle, -> ARB. Earliest re-grant 1 cycle after done.
//  Latency: req (card_rdy, engine idle) -> gnt 1 cycle, gnt -> sd_ren 1 cycle.
//  Requester dropping req after gnt is ignored; read completes, done still pulsed.
//  sd_read_ok outside RD_WAIT ignored. Timeout counter saturates, cleared on every state entry.
//  rst mid-operation: immediate return to reset values; card_rdy=0 forces re-init.
//  Never more than one of gnt0/gnt1/done*/err* per port per cycle; sd_init and sd_ren mutually exclusive.
// CONFIGURATION
//  SD_TIMEOUT_EN defined: TIMEOUT_CYC counter active in INIT and RD_WAIT. RD_WAIT timeout ->
//   errN pulse, card_rdy=0, -> INIT (card re-initialised before next read).
//  SD_TIMEOUT_EN undefined: no counter logic; INIT and RD_WAIT wait indefinitely; init_fail
//   tied 0, err0/err1 tied 0.
// TESTING
//  T1 req0=1 addr0=0x10, init_ok rises 20 cycles after sd_init -> sd_init 20 cycles, gnt0,
//     sd_ren 1 cycle with sd_addr=0x10, sd_read_ok -> done0 next cycle, card_rdy=1.
//  T2 card_rdy=1, req0=req1=1 held, 4 reads -> grant order 0,1,0,1; no gnt before prior done.
//  T3 sd_busy=1 for 7 cycles after gnt1 -> sd_ren delayed, asserted first cycle sd_busy=0.
//  T4 (SD_TIMEOUT_EN, TIMEOUT_CYC=100, MAX_RETRY=3) init_ok never rises -> 3 sd_init attempts,
//     init_fail=1, err0 pulse; later req1 -> err1 pulse, no sd_init.
//  T5 (SD_TIMEOUT_EN) sd_read_ok withheld -> err pulse after 100 cycles, card_rdy=0, re-INIT.
//  T6 rst asserted during RD_WAIT -> next cycle all outputs 0, state IDLE, req re-runs INIT.

Source files
------------

// File: rtl/sd_access_sched.sv
// sd_access_sched: shares the SD SPI engine (init + single-block read) between two
// requesters. Port 0 is the UART command path, port 1 the front-end logic.
// The card is initialised once before any read; reads are round-robin arbitrated.
// Optional feature macro: SD_TIMEOUT_EN enables the TIMEOUT_CYC watchdog in INIT and
// RD_WAIT, the init retry limit, sticky init_fail and the err0/err1 pulses. Without
// it, both states wait indefinitely and init_fail/err0/err1 stay 0.
module sd_access_sched #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 65535,
  parameter int MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic              sd_init,
  input  logic              init_ok,
  output logic              sd_ren,
  output logic [ADDR_W-1:0] sd_addr,
  input  logic              sd_read_ok,
  input  logic              sd_busy,
  output logic              card_rdy,
  output logic              init_fail
);

  typedef enum logic [2:0] {
    IDLE, INIT, REARM, ARB, RD_ISSUE, RD_WAIT, FAIL
  } state_t;

  state_t     state;
  logic [3:0] retry_cnt;
  logic       last_gnt;   // port granted most recently; the other port wins a tie
  logic       timeout;    // current INIT / RD_WAIT visit has run out of time

`ifdef SD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt;

  // Watchdog: counts cycles spent in INIT or RD_WAIT, restarting on every entry.
  // Leaving either state always passes through a timeout or a non-counted state,
  // so clearing on those conditions is equivalent to clearing on entry.
  always_ff @(posedge clk) begin
    if (rst || !(state inside {INIT, RD_WAIT}) || timeout)
      tmo_cnt <= '0;
    else if (tmo_cnt != CW'(TIMEOUT_CYC))
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = (state inside {INIT, RD_WAIT}) && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // Main sequencer: every output is a register written only here.
  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from the values sampled at the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      retry_cnt <= '0;
      last_gnt  <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      sd_init   <= 1'b0;
      sd_ren    <= 1'b0;
      sd_addr   <= '0;
      card_rdy  <= 1'b0;
      init_fail <= 1'b0;
    end else begin
      // Single-cycle pulses fall back to 0 unless a state below re-asserts them.
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      sd_ren <= 1'b0;

      case (state)
        IDLE: begin
          if (init_fail) begin
            // Card is unusable: bounce each request once (its err pulse is still
            // visible while the requester withdraws, so do not pulse twice).
            err0 <= req0 & ~err0;
            err1 <= req1 & ~err1;
          end else if (req0 || req1) begin
            if (card_rdy) begin
              state <= ARB;
            end else begin
              sd_init <= 1'b1;
              state   <= INIT;
            end
          end
        end

        INIT: begin
          if (init_ok) begin
            sd_init   <= 1'b0;
            card_rdy  <= 1'b1;
            retry_cnt <= '0;
            state     <= ARB;
          end else if (timeout) begin
            sd_init   <= 1'b0;
            retry_cnt <= retry_cnt + 4'd1;
            state     <= (retry_cnt == 4'(MAX_RETRY - 1)) ? FAIL : REARM;
          end
        end

        // One low cycle on sd_init so the engine sees a fresh start request.
        REARM: begin
          sd_init <= 1'b1;
          state   <= INIT;
        end

        ARB: begin
          if (!init_ok) begin
            card_rdy <= 1'b0;
            sd_init  <= 1'b1;
            state    <= INIT;
          end else if (req0 && (!req1 || last_gnt)) begin
            gnt0     <= 1'b1;
            sd_addr  <= addr0;
            last_gnt <= 1'b0;
            state    <= RD_ISSUE;
          end else if (req1) begin
            gnt1     <= 1'b1;
            sd_addr  <= addr1;
            last_gnt <= 1'b1;
            state    <= RD_ISSUE;
          end
        end

        RD_ISSUE: begin
          if (!sd_busy) begin
            sd_ren <= 1'b1;
            state  <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (sd_read_ok) begin
            done0 <= ~last_gnt;
            done1 <= last_gnt;
            state <= ARB;
          end else if (timeout) begin
            err0     <= ~last_gnt;
            err1     <= last_gnt;
            card_rdy <= 1'b0;
            sd_init  <= 1'b1;
            state    <= INIT;
          end
        end

        FAIL: begin
          init_fail <= 1'b1;
          err0      <= req0;
          err1      <= req1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_access_sched.sv
// Self-checking bench for sd_access_sched. The bench plays the SD engine itself and
// predicts grant order from the round-robin rule (a tie goes to the port that was not
// granted last; port 0 wins the first tie after reset). Outputs are sampled and inputs
// driven on the falling clock edge.
module tb_sd_access_sched;

  localparam int ADDR_W = 32;
  localparam int TMO    = 100;
  localparam int MAXR   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              gnt0, gnt1, done0, done1, err0, err1;
  logic              sd_init, init_ok, sd_ren, sd_read_ok, sd_busy;
  logic [ADDR_W-1:0] sd_addr;
  logic              card_rdy, init_fail;

  int vectors    = 0;
  int miscompares = 0;
  int model_last = 1;   // port granted most recently, as the arbitration rule sees it

  sd_access_sched #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .sd_init(sd_init), .init_ok(init_ok), .sd_ren(sd_ren), .sd_addr(sd_addr),
    .sd_read_ok(sd_read_ok), .sd_busy(sd_busy),
    .card_rdy(card_rdy), .init_fail(init_fail)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  // Round-robin rule: pend bit0 = port 0, bit1 = port 1.
  function automatic int pick(input logic [1:0] pend, input int last);
    if (pend == 2'b11) return 1 - last;
    return pend[1] ? 1 : 0;
  endfunction

  // Cycle-level invariants that must hold at every sample point.
  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if ((sd_init && sd_ren) || (gnt0 && (done0 || err0)) || (gnt1 && (done1 || err1))
          || (done0 && err0) || (done1 && err1)) begin
        miscompares++;
        $display("FAIL invariant: init=%b ren=%b gnt=%b%b done=%b%b err=%b%b",
                 sd_init, sd_ren, gnt1, gnt0, done1, done0, err1, err0);
      end
`ifndef SD_TIMEOUT_EN
      vectors++;
      if ({err1, err0, init_fail} !== 3'b000) begin
        miscompares++;
        $display("FAIL no_timeout_outputs: err=%b%b init_fail=%b expected 0", err1, err0, init_fail);
      end
`endif
    end
  end

  task automatic do_reset;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    init_ok = 1'b0; sd_read_ok = 1'b0; sd_busy = 1'b0;
    tick; tick;
    vectors++;
    if ({gnt0, gnt1, done0, done1, err0, err1, sd_init, sd_ren, card_rdy, init_fail} !== 10'b0
        || sd_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: flags=%b sd_addr=%h expected all 0",
               {gnt0, gnt1, done0, done1, err0, err1, sd_init, sd_ren, card_rdy, init_fail}, sd_addr);
    end
    rst = 1'b0;
    model_last = 1;
  endtask

  // Request(s) already driven; expect sd_init next cycle, held exactly `delay` cycles
  // until the bench raises init_ok, then card_rdy.
  task automatic do_init(input int delay);
    for (int c = 0; c < delay; c++) begin
      tick;
      vectors++;
      if (sd_init !== 1'b1 || card_rdy !== 1'b0) begin
        miscompares++;
        $display("FAIL init_hold[%0d]: sd_init=%b card_rdy=%b expected 1/0", c, sd_init, card_rdy);
      end
    end
    init_ok = 1'b1;
    tick;
    vectors++;
    if (sd_init !== 1'b0 || card_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL init_done: sd_init=%b card_rdy=%b expected 0/1", sd_init, card_rdy);
    end
  endtask

  // One full read with the card ready and requests already driven: grant one cycle
  // later, sd_ren after the busy window, done one cycle after sd_read_ok.
  task automatic serve(input int busy_cyc, input int lat, input int exp_port,
                       input logic [ADDR_W-1:0] exp_addr);
    logic [1:0] exp_oh;
    exp_oh = (exp_port == 0) ? 2'b01 : 2'b10;
    tick;
    vectors++;
    if ({gnt1, gnt0} !== exp_oh || sd_addr !== exp_addr) begin
      miscompares++;
      $display("FAIL grant: gnt=%b addr=%h expected gnt=%b addr=%h", {gnt1, gnt0}, sd_addr, exp_oh, exp_addr);
    end
    sd_busy = (busy_cyc > 0);
    for (int k = 0; k < busy_cyc; k++) begin
      tick;
      vectors++;
      if ({sd_ren, gnt1, gnt0} !== 3'b000) begin
        miscompares++;
        $display("FAIL busy_wait[%0d]: ren/gnt=%b expected 000", k, {sd_ren, gnt1, gnt0});
      end
      if (k == busy_cyc - 1) sd_busy = 1'b0;
    end
    tick;
    vectors++;
    if (sd_ren !== 1'b1 || sd_addr !== exp_addr || {gnt1, gnt0} !== 2'b00) begin
      miscompares++;
      $display("FAIL strobe: sd_ren=%b addr=%h gnt=%b expected 1 %h 00", sd_ren, sd_addr, {gnt1, gnt0}, exp_addr);
    end
    for (int k = 0; k < lat; k++) begin
      tick;
      vectors++;
      if ({sd_ren, done1, done0, gnt1, gnt0} !== 5'b0 || sd_addr !== exp_addr) begin
        miscompares++;
        $display("FAIL read_wait[%0d]: ren/done/gnt=%b addr=%h expected 0 %h", k,
                 {sd_ren, done1, done0, gnt1, gnt0}, sd_addr, exp_addr);
      end
    end
    sd_read_ok = 1'b1;
    tick;
    sd_read_ok = 1'b0;
    vectors++;
    if ({done1, done0} !== exp_oh) begin
      miscompares++;
      $display("FAIL done: done=%b expected %b", {done1, done0}, exp_oh);
    end
    model_last = exp_port;
  endtask

  task automatic test_reset;
    do_reset;
  endtask

  task automatic test_init_read;
    req0 = 1'b1; addr0 = 32'h10;
    do_init(20);
    serve(0, 3, pick(2'b01, model_last), 32'h10);
    req0 = 1'b0;
    tick;
    vectors++;
    if (card_rdy !== 1'b1 || {gnt1, gnt0, done1, done0} !== 4'b0) begin
      miscompares++;
      $display("FAIL after_read: card_rdy=%b gnt/done=%b expected 1 0000", card_rdy, {gnt1, gnt0, done1, done0});
    end
  endtask

  task automatic test_round_robin;
    do_reset;
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'hA000_0000; addr1 = 32'h0000_B001;
    do_init(5);
    for (int i = 0; i < 4; i++) begin
      int p;
      p = pick(2'b11, model_last);
      serve(0, 2, p, (p == 1) ? addr1 : addr0);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_busy;
    req1 = 1'b1; addr1 = $urandom;
    serve(7, 2, pick(2'b10, model_last), addr1);
    req1 = 1'b0;
  endtask

  task automatic test_random;
    logic [1:0] pend, r;
    pend = 2'b00;
    for (int it = 0; it < 40; it++) begin
      int p;
      r = 2'($urandom_range(0, 3));
      if (r[0] && !pend[0]) addr0 = $urandom;
      if (r[1] && !pend[1]) addr1 = $urandom;
      pend = pend | r;
      if (pend == 2'b00) begin
        pend = 2'b01;
        addr0 = $urandom;
      end
      req0 = pend[0]; req1 = pend[1];
      p = pick(pend, model_last);
      serve($urandom_range(0, 3), $urandom_range(1, 4), p, (p == 1) ? addr1 : addr0);
      pend[p] = 1'b0;
      req0 = pend[0]; req1 = pend[1];
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [ADDR_W-1:0] a;
    a = $urandom;
    req0 = 1'b1; addr0 = a;
    tick;
    vectors++;
    if ({gnt1, gnt0} !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_grant: gnt=%b expected 01", {gnt1, gnt0});
    end
    tick;
    vectors++;
    if (sd_ren !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_strobe: sd_ren=%b expected 1", sd_ren);
    end
    tick; tick;
    rst = 1'b1; init_ok = 1'b0;
    tick;
    vectors++;
    if ({gnt0, gnt1, done0, done1, err0, err1, sd_init, sd_ren, card_rdy, init_fail} !== 10'b0
        || sd_addr !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: flags=%b sd_addr=%h expected all 0",
               {gnt0, gnt1, done0, done1, err0, err1, sd_init, sd_ren, card_rdy, init_fail}, sd_addr);
    end
    rst = 1'b0;
    model_last = 1;
    do_init(4);
    serve(1, 2, pick(2'b01, model_last), a);
    req0 = 1'b0;
  endtask

`ifdef SD_TIMEOUT_EN
  task automatic test_init_timeout;
    int rises, high;
    bit got_err;
    do_reset;
    req0 = 1'b1;
    rises = 0; high = 0; got_err = 1'b0;
    for (int c = 0; c < 500 && !got_err; c++) begin
      tick;
      if (sd_init) begin
        high++;
      end else if (high > 0) begin
        rises++;
        vectors++;
        if (high != TMO) begin
          miscompares++;
          $display("FAIL init_attempt_len: %0d cycles expected %0d", high, TMO);
        end
        high = 0;
      end
      if (err0) got_err = 1'b1;
    end
    vectors++;
    if (!got_err || rises != MAXR || init_fail !== 1'b1 || gnt0 !== 1'b0) begin
      miscompares++;
      $display("FAIL init_give_up: err0_seen=%0d attempts=%0d init_fail=%b expected 1 %0d 1",
               got_err, rises, init_fail, MAXR);
    end
    req0 = 1'b0;
    tick; tick;
    req1 = 1'b1;
    tick;
    vectors++;
    if (err1 !== 1'b1 || sd_init !== 1'b0 || gnt1 !== 1'b0) begin
      miscompares++;
      $display("FAIL failed_card_req: err1=%b sd_init=%b gnt1=%b expected 1 0 0", err1, sd_init, gnt1);
    end
    req1 = 1'b0;
    tick;
    vectors++;
    if (err1 !== 1'b0 || init_fail !== 1'b1) begin
      miscompares++;
      $display("FAIL err_single_pulse: err1=%b init_fail=%b expected 0 1", err1, init_fail);
    end
  endtask

  task automatic test_read_timeout;
    int waited;
    do_reset;
    req0 = 1'b1; addr0 = $urandom;
    do_init(3);
    tick;
    tick;
    vectors++;
    if (sd_ren !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_strobe: sd_ren=%b expected 1", sd_ren);
    end
    waited = -1;
    for (int c = 1; c <= 300 && waited < 0; c++) begin
      tick;
      if (err0) waited = c;
    end
    vectors++;
    if (waited != TMO || card_rdy !== 1'b0 || sd_init !== 1'b1) begin
      miscompares++;
      $display("FAIL read_timeout: err0 after %0d cycles card_rdy=%b sd_init=%b expected %0d 0 1",
               waited, card_rdy, sd_init, TMO);
    end
    req0 = 1'b0;
    tick;
    vectors++;
    if (card_rdy !== 1'b1 || sd_init !== 1'b0) begin
      miscompares++;
      $display("FAIL reinit: card_rdy=%b sd_init=%b expected 1 0", card_rdy, sd_init);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_init_read;
    test_round_robin;
    test_busy;
    test_random;
    test_reset_mid;
`ifdef SD_TIMEOUT_EN
    test_init_timeout;
    test_read_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
